bist_sched: RTL

BIST_SCHED -- requirements
Module: bist_sched

---
 rtl/bist_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bist_sched.sv
// bist_sched: schedules one BIST session per host request and judges the result.
//
// A session arms (clears the MISR, pattern counter and timers), starts the BIST
// engine, compacts every engine response into a MISR while the engine runs, then
// compares the signature and pattern count against their expected values.
//
// Host handshake: req is a level request. A session starts when req is seen high
// in IDLE. done rises in REPORT and stays high until req is seen low, after which
// the FSM returns to IDLE. Holding req high in REPORT never starts a new session;
// the host must drop req and raise it again. Dropping req mid-session does not
// abort it: the result is still shown in REPORT for one cycle.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset, priority over everything
//   req          host test request (level)
//   eng_running  engine RUNNING status
//   eng_out      engine applies a pattern this cycle (cut_resp valid)
//   eng_end      engine BIST_END
//   cut_resp     circuit-under-test response [SIG_W]
//   eng_start    START level to the engine (LAUNCH and RUN)
//   busy         session in progress (not IDLE, not REPORT)
//   done         result valid (REPORT)
//   pass         verdict, held until the next CHECK or reset
//   tmo_err      session ended by a timeout, held like pass
//   signature    MISR contents, frozen from CHECK until the next ARM [SIG_W]
//   fsm_state    current FSM state encoding, for observation [3]
module bist_sched #(
    parameter int               SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] GOLDEN     = '0,
    parameter int               EXP_PAT    = 81,
    parameter int               RUN_TMO    = 200,
    parameter int               LAUNCH_TMO = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             eng_running,
    input  logic             eng_out,
    input  logic             eng_end,
    input  logic [SIG_W-1:0] cut_resp,
    output logic             eng_start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             tmo_err,
    output logic [SIG_W-1:0] signature,
    output logic [2:0]       fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_CHECK  = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    localparam int TMR_MAX = (RUN_TMO > LAUNCH_TMO) ? RUN_TMO : LAUNCH_TMO;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic             tmo_hit;
    logic [TMR_W-1:0] tmr;
    logic [SIG_W-1:0] misr;
    logic [SIG_W-1:0] misr_nxt;
    logic [7:0]       pat_cnt;
    logic             tmo_flag;
    logic             compact;
    logic             timed_state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; tmo_hit marks a LAUNCH/RUN exit caused by a timer expiry.
    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) state_nxt = S_ARM;
            end
            S_ARM: begin
                // tmr counts cycles spent in the current state, so ARM lasts two
                if (tmr == TMR_W'(1)) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (eng_running) begin
                    state_nxt = S_RUN;
                end else if (tmr == TMR_W'(LAUNCH_TMO - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_RUN: begin
                if (eng_end) begin
                    state_nxt = S_CHECK;
                end else if (tmr == TMR_W'(RUN_TMO - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = S_REPORT;
            end
            S_REPORT: begin
                if (!req) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        eng_start = (state == S_LAUNCH) || (state == S_RUN);
        busy      = (state != S_IDLE) && (state != S_REPORT);
        done      = (state == S_REPORT);
        signature = misr;
        fsm_state = state;
    end

    // Responses are compacted only in RUN, including the cycle that carries eng_end.
    assign compact     = (state == S_RUN) && eng_out;
    assign timed_state = (state == S_ARM) || (state == S_LAUNCH) || (state == S_RUN);
    assign misr_nxt    = {misr[SIG_W-2:0], 1'b0} ^ (misr[SIG_W-1] ? POLY : '0) ^ cut_resp;

    // Datapath: MISR, pattern counter, state timer and verdict registers
    always_ff @(posedge clk) begin
        if (reset) begin
            misr     <= '0;
            pat_cnt  <= '0;
            tmr      <= '0;
            tmo_flag <= 1'b0;
            pass     <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            if (state == S_ARM) begin
                misr     <= '0;
                pat_cnt  <= '0;
                tmo_flag <= 1'b0;
            end
            if (compact) begin
                misr <= misr_nxt;
                if (pat_cnt != 8'hFF) pat_cnt <= pat_cnt + 8'd1;
            end
            if (tmo_hit) tmo_flag <= 1'b1;

            // Restart on every state change so each timed state starts from zero
            if (!timed_state || (state_nxt != state)) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end

            if (state == S_CHECK) begin
                pass    <= (misr == GOLDEN) && (pat_cnt == 8'(EXP_PAT)) && !tmo_flag;
                tmo_err <= tmo_flag;
            end
        end
    end

endmodule
